// File: rtl/gpio_write_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_write_port_if
//  Description : Data-memory-stage bus carrying load/store strobes, address,
//                store data and the registered load response back from the
//                GPIO port. The stage that drives addresses uses the master
//                modport. The GPIO port uses the slave modport.
//  Signals     : addr   [31:0] word address
//                wdata  [31:0] store data
//                we            store strobe, one cycle per store
//                re            load strobe, one cycle per load
//                rdata  [31:0] registered load data
//                rvalid        rdata valid for one cycle
//                hit           combinational address-hit indication
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_write_port_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        hit;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rvalid, hit
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rvalid, hit
  );
endinterface
`default_nettype wire

// File: rtl/gpio_write_port.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_write_port
//  Description : Memory-mapped GPIO block. It provides a writable and readable
//                output register at GPIO_ADDR. It provides a read-only,
//                2-flop-synchronised view of the input pins at IN_ADDR. A
//                sticky change flag records transitions on the synchronised
//                inputs.
//  Ports       : clk       rising-edge clock
//                rst_n     asynchronous active-low reset
//                bus       gpio_write_port_if.slave (addr/wdata/we/re in,
//                          rdata/rvalid/hit out)
//                gpio_in   [GPIO_W-1:0] asynchronous external pins
//                gpio_out  [GPIO_W-1:0] registered output pins
//                wr_pulse  one-cycle pulse following each accepted GPIO write
//                chg       sticky input-change flag, cleared by reading IN_ADDR
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_write_port #(
  parameter logic [31:0]       GPIO_ADDR = 32'h0000ABCD,
  parameter logic [31:0]       IN_ADDR   = 32'h0000ABD0,
  parameter int                GPIO_W    = 16,
  parameter logic [GPIO_W-1:0] OUT_RST   = '0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  gpio_write_port_if.slave       bus,
  input  wire logic [GPIO_W-1:0] gpio_in,
  output      logic [GPIO_W-1:0] gpio_out,
  output      logic              wr_pulse,
  output      logic              chg
);

  localparam logic [1:0] C_ARM_MAX = 2'd3;

  // ---------------------------------------------------------------- state
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] s1_q;
  logic [GPIO_W-1:0] sync_in_q;
  logic [GPIO_W-1:0] prev_q;
  logic [1:0]        arm_cnt_q, arm_cnt_d;
  logic              chg_q, chg_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q;
  logic              wr_pulse_q;

  // ---------------------------------------------------------------- decode
  logic w_sel_gpio;
  logic w_sel_in;
  logic w_wr_gpio;
  logic w_rd_in;
  logic w_armed;
  logic w_chg_set;
  logic w_unused_wdata;

  // Full 32-bit compares, so there is no aliasing of the two registers.
  assign w_sel_gpio = (bus.addr == GPIO_ADDR);
  assign w_sel_in   = (bus.addr == IN_ADDR);
  assign w_wr_gpio  = bus.we & w_sel_gpio;
  assign w_rd_in    = bus.re & w_sel_in;

  // Reset does not gate hit. It is a pure function of the bus inputs.
  assign bus.hit = (bus.we | bus.re) & (w_sel_gpio | w_sel_in);

  // The first edges after reset release move the reset zeros through
  // s1/sync_in/prev. Change detection stays blocked until that has settled.
  assign w_armed   = (arm_cnt_q == C_ARM_MAX);
  assign w_chg_set = w_armed & (sync_in_q != prev_q);

  // Only wdata[GPIO_W-1:0] reaches a register.
  assign w_unused_wdata = ^bus.wdata;

  // ---------------------------------------------------------------- next state
  always_comb begin
    gpio_out_d = gpio_out_q;
    arm_cnt_d  = arm_cnt_q;
    chg_d      = chg_q;
    rdata_d    = rdata_q;

    if (w_wr_gpio) begin
      gpio_out_d = bus.wdata[GPIO_W-1:0];
    end

    if (!w_armed) begin
      arm_cnt_d = arm_cnt_q + 2'd1;
    end

    // Set takes priority over the read-clear, so a change that lands in the
    // same cycle as a read is not lost.
    if (w_chg_set) begin
      chg_d = 1'b1;
    end else if (w_rd_in) begin
      chg_d = 1'b0;
    end

    // The read samples gpio_out_q, so a write in the same cycle returns the
    // value held before that write.
    if (bus.re) begin
      if (w_sel_gpio) begin
        rdata_d = 32'(gpio_out_q);
      end else if (w_sel_in) begin
        rdata_d = 32'(sync_in_q);
      end else begin
        rdata_d = 32'h0;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q <= OUT_RST;
      s1_q       <= '0;
      sync_in_q  <= '0;
      prev_q     <= '0;
      arm_cnt_q  <= 2'd0;
      chg_q      <= 1'b0;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      s1_q       <= gpio_in;
      sync_in_q  <= s1_q;
      prev_q     <= sync_in_q;
      arm_cnt_q  <= arm_cnt_d;
      chg_q      <= chg_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= bus.re;
      wr_pulse_q <= w_wr_gpio;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign gpio_out   = gpio_out_q;
  assign wr_pulse   = wr_pulse_q;
  assign chg        = chg_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule
`default_nettype wire

// File: doc/gpio_write_port.md
GPIO_WRITE_PORT -- requirements
Module: gpio_write_port

Interface
REQ-001 Parameter GPIO_ADDR, default 32'h0000ABCD: word address of the GPIO output register (write/read).
REQ-002 Parameter IN_ADDR, default 32'h0000ABD0: word address of the synchronized GPIO input (read-only).
REQ-003 Parameter GPIO_W, default 16: GPIO pin count (1..32).
REQ-004 Parameter OUT_RST, default 0: reset value of gpio_out.
REQ-005 The block SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 addr  input  32  bus address from the data-memory stage.
REQ-009 wdata  input  32  store data.
REQ-010 we  input  1  store strobe, one cycle per store.
REQ-011 re  input  1  load strobe, one cycle per load.
REQ-012 gpio_in  input  GPIO_W  asynchronous external pins.
REQ-013 gpio_out  output  GPIO_W  registered output pins.
REQ-014 wr_pulse  output  1  one-cycle pulse after each accepted GPIO write.
REQ-015 rdata  output  32  registered load data.
REQ-016 rvalid  output  1  rdata valid, one cycle.
REQ-017 hit  output  1  combinational: (we|re) and addr equals GPIO_ADDR or IN_ADDR.
REQ-018 chg  output  1  sticky input-change flag.

Function
REQ-019 Address decode SHALL be full 32-bit equality; there is no partial decode or aliasing.
REQ-020 On an edge with we=1 and addr==GPIO_ADDR: gpio_out <= wdata[GPIO_W-1:0]; wr_pulse=1 for the following cycle only.
REQ-021 A write to IN_ADDR or to any unmapped address SHALL be ignored, with no wr_pulse.
REQ-022 Back-to-back writes on consecutive cycles SHALL each update gpio_out and each produce a wr_pulse, so wr_pulse stays high continuously.
REQ-023 On an edge with re=1: rvalid=1 in the next cycle. rdata is:
  - zero-extended gpio_out when addr==GPIO_ADDR;
  - zero-extended sync_in when addr==IN_ADDR;
  - 0 otherwise.
REQ-024 With re=0, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-025 With we=1 and re=1 to GPIO_ADDR in the same cycle, the read SHALL return the pre-write gpio_out value.
REQ-026 gpio_in SHALL pass through a 2-flop synchronizer (s1 -> sync_in); latency from pin to sync_in is 2 edges.
REQ-027 A register prev SHALL capture sync_in every edge.
REQ-028 chg SHALL be set on the edge after the cycle in which sync_in != prev and armed=1.
REQ-029 chg SHALL clear on the edge of a read (re=1) of IN_ADDR.
REQ-030 If set and clear coincide, set SHALL win and chg remains 1.
REQ-031 Arming: a 2-bit counter SHALL count from 0 after reset release; armed=1 once it saturates at 3. This suppresses the spurious change caused by reset values.

Reset
REQ-032 While rst_n=0, the following SHALL be forced immediately, independent of clk:
  - gpio_out=OUT_RST;
  - s1=0, sync_in=0, prev=0;
  - chg=0, arm counter=0;
  - rdata=0, rvalid=0, wr_pulse=0.
REQ-033 Reset asserted mid-transaction SHALL discard that transaction; no wr_pulse or rvalid may appear after release.
REQ-034 hit SHALL remain purely combinational and unaffected by reset.

Verification
REQ-035 Reset, then write addr=0xABCD, wdata=0x1234A5A5 -> next cycle gpio_out=0xA5A5, wr_pulse high for exactly 1 cycle, hit=1 during the write cycle.
REQ-036 Write addr=0xABCC, wdata=0xFFFF -> gpio_out unchanged, wr_pulse=0, hit=0; read 0xABCC -> rvalid=1, rdata=0.
REQ-037 Same cycle: we=1 and re=1 at 0xABCD, old=0x0001, new=0x0002 -> rdata=0x00000001, gpio_out=0x0002 on the next cycle.
REQ-038 gpio_in=0x00F0 held through reset release -> chg stays 0. Then gpio_in -> 0x00F1 -> sync_in=0x00F1 after 2 edges, chg=1 one edge later; read 0xABD0 -> rdata=0x000000F1, chg=0.
REQ-039 Input changes on the same edge as a read of 0xABD0 clears chg -> chg remains 1.
REQ-040 rst_n pulsed low mid-cycle after a write with gpio_out=0x5A5A -> gpio_out=OUT_RST immediately, no wr_pulse or rvalid after release.
